mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `Wallace_Tree_Multiplier` (8x8 → 16, combinational) between `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and registers the operands into the multiplier inputs. It then registers the product and returns it on a single tagged response channel with backpressure. It sits between the requesting engines and the multiplier, and puts registers at both ends of the multiplier so that path is timed register-to-register.

---
 rtl/mult_arb_pkg.sv | 31 +++
 rtl/Wallace_Tree_Multiplier.sv | 17 +
 rtl/rr_grant.sv | 23 ++
 rtl/mult_arbiter.sv | 108 ++++++++++
 tb/tb_mult_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// operand/product widths, operand payload and the clog2 helper.
package mult_arb_pkg;

    localparam int unsigned OP_W = 8;
    localparam int unsigned P_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

    // Smallest r with 2**r >= n (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/Wallace_Tree_Multiplier.sv
// Shared 8x8 -> 16 unsigned combinational multiplier (partial-product sum).
module Wallace_Tree_Multiplier (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (B[i]) begin
                sum = sum + (16'(A) << i);
            end
        end
    end

endmodule

// File: rtl/rr_grant.sv
// Round-robin one-hot grant: first asserted request at or after ptr, wrapping.
module rr_grant #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;
    logic [2*N-1:0] gnt_dbl;

    // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];
    assign gnt_rot = req_rot & (-req_rot);
    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    assign gnt     = gnt_dbl[2*N-1:N];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one multiplier between NUM_REQ requesters,
// with registered operands and product around the multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_a,
    input  logic [NUM_REQ*OP_W-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [P_W-1:0]            rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     nxt_ptr;
    logic [NUM_REQ-1:0]  gnt;
    operands_t           ops;
    operands_t           sel_ops;
    logic [P_W-1:0]      product;
    logic                accept;

    rr_grant #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_grant (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    Wallace_Tree_Multiplier u_mul (
        .A   (ops.a),
        .B   (ops.b),
        .sum (product)
    );

    // Encode the one-hot grant and mux the granted requester's operands.
    always_comb begin
        gnt_idx = '0;
        sel_ops = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx   = ID_W'(i);
                sel_ops.a = req_a[i*OP_W +: OP_W];
                sel_ops.b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    assign nxt_ptr   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            ops       <= '0;
            id_q      <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ops   <= sel_ops;
                        id_q  <= gnt_idx;
                        ptr   <= nxt_ptr;
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    rsp_data  <= product;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mult_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned IW = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*8-1:0]   req_a;
    logic [N*8-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        int          who;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int id;
        int prod;
        int acc;
    } txn_t;

    always #5 clk = ~clk;

    mult_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset(input bit check);
        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick(); tick(); settle();
        if (check) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Called just after an accept cycle; returns cycles from accept to rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            req_valid = '0;
            lat++;
            settle();
            if (rsp_valid) return;
        end
        lat = -1;
    endtask

    task automatic test_table();
        vec_t vecs[$];
        int lat;
        logic [N-1:0] oh;
        vecs.push_back('{0, 8'hFF, 8'hFF, 16'hFE01});
        vecs.push_back('{0, 8'h03, 8'h05, 16'h000F});
        vecs.push_back('{1, 8'h07, 8'h09, 16'h003F});
        vecs.push_back('{0, 8'h00, 8'hFF, 16'h0000});
        vecs.push_back('{1, 8'h01, 8'hFF, 16'h00FF});
        vecs.push_back('{1, 8'h80, 8'h02, 16'h0100});
        vecs.push_back('{0, 8'hAA, 8'h55, 16'h3872});
        vecs.push_back('{1, 8'hFF, 8'h01, 16'h00FF});
        foreach (vecs[v]) begin
            tick();
            set_req(vecs[v].who, vecs[v].a, vecs[v].b);
            oh = '0;
            oh[vecs[v].who] = 1'b1;
            req_valid = oh;
            rsp_ready = 1'b1;
            settle();
            chk("tbl_req_ready", 32'(req_ready), 32'(oh));
            wait_rsp(lat);
            chk("tbl_latency", 32'(lat), 2);
            chk("tbl_rsp_data", 32'(rsp_data), 32'(vecs[v].exp));
            chk("tbl_rsp_id", 32'(rsp_id), 32'(vecs[v].who));
            chk("tbl_busy", 32'(busy), 1);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention();
        int acc_n = 0, rsp_n = 0, g;
        int acc_cyc[2], acc_id[2], rid[2];
        logic [15:0] rd[2];
        logic [N-1:0] drop;
        acc_cyc = '{0, 0}; acc_id = '{-1, -1}; rid = '{-1, -1}; rd = '{0, 0};
        do_reset(0);
        tick();
        set_req(0, 8'd3, 8'd5);
        set_req(1, 8'd7, 8'd9);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 30 && rsp_n < 2; k++) begin
            settle();
            drop = '0;
            g = oh2i(req_ready);
            if (g >= 0 && acc_n < 2) begin
                acc_cyc[acc_n] = cyc; acc_id[acc_n] = g; acc_n++;
                drop[g] = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                rd[rsp_n] = rsp_data; rid[rsp_n] = int'(rsp_id); rsp_n++;
            end
            tick();
            req_valid = req_valid & ~drop;
        end
        chk("cont_accepts", 32'(acc_n), 2);
        chk("cont_first_id", 32'(acc_id[0]), 0);
        chk("cont_second_id", 32'(acc_id[1]), 1);
        chk("cont_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 3);
        chk("cont_rsp0_data", 32'(rd[0]), 15);
        chk("cont_rsp0_id", 32'(rid[0]), 0);
        chk("cont_rsp1_data", 32'(rd[1]), 63);
        chk("cont_rsp1_id", 32'(rid[1]), 1);
        req_valid = '0;
    endtask

    task automatic test_fairness();
        int gseq[6];
        int n = 0;
        gseq = '{-1, -1, -1, -1, -1, -1};
        do_reset(0);
        tick();
        set_req(0, 8'd11, 8'd2);
        set_req(1, 8'd13, 8'd3);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && n < 6; k++) begin
            settle();
            if (req_ready != '0) begin
                gseq[n] = oh2i(req_ready);
                n++;
            end
            tick();
        end
        req_valid = '0;
        chk("fair_count", 32'(n), 6);
        for (int j = 0; j < 6; j++) chk("fair_grant_order", 32'(gseq[j]), 32'(j % 2));
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset(0);
        tick();
        set_req(0, 8'h80, 8'h02);
        set_req(1, 8'h05, 8'h05);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        settle();
        chk("bp_accept", 32'(req_ready), 32'b01);
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 2);
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            tick();
            settle();
            chk("bp_hold_data", 32'(rsp_data), 32'h0100);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_ready", 32'(req_ready), 0);
            chk("bp_hold_busy", 32'(busy), 1);
        end
        tick();
        rsp_ready = 1'b1;
        settle();
        chk("bp_release_valid", 32'(rsp_valid), 1);
        tick();
        settle();
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_idle_valid", 32'(rsp_valid), 0);
        chk("bp_idle_grant", 32'(req_ready), 32'b10);
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset(0);
        tick();
        set_req(0, 8'd9, 8'd9);
        set_req(1, 8'd9, 8'd9);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        settle();
        chk("rm_accept", 32'(req_ready), 32'b01);
        tick();
        req_valid = '1;
        settle();
        chk("rm_calc_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rm_busy", 32'(busy), 0);
        chk("rm_rsp_valid", 32'(rsp_valid), 0);
        chk("rm_rsp_data", 32'(rsp_data), 0);
        chk("rm_rsp_id", 32'(rsp_id), 0);
        chk("rm_req_ready", 32'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_req(0, 8'd2, 8'd3);
        set_req(1, 8'd4, 8'd5);
        settle();
        chk("rm_ptr_cleared", 32'(req_ready), 32'b01);
        wait_rsp(lat);
        chk("rm_latency", 32'(lat), 2);
        chk("rm_rsp_data_new", 32'(rsp_data), 6);
        chk("rm_rsp_id_new", 32'(rsp_id), 0);
        tick();
    endtask

    task automatic test_random();
        txn_t q[$];
        int mptr = 0;
        int g, idx;
        logic [N-1:0] exp_rdy;
        do_reset(0);
        for (int k = 0; k < 800; k++) begin
            tick();
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            req_a     = (N*8)'($urandom);
            req_b     = (N*8)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();
            if (q.size() > 0) begin
                chk("rnd_busy", 32'(busy), 1);
                chk("rnd_ready_blocked", 32'(req_ready), 0);
                chk("rnd_rsp_valid", 32'(rsp_valid), 32'((cyc - q[0].acc) >= 2));
                if (rsp_valid) begin
                    chk("rnd_rsp_data", 32'(rsp_data), 32'(q[0].prod));
                    chk("rnd_rsp_id", 32'(rsp_id), 32'(q[0].id));
                    if (rsp_ready) void'(q.pop_front());
                end
            end else begin
                chk("rnd_idle_busy", 32'(busy), 0);
                chk("rnd_idle_valid", 32'(rsp_valid), 0);
                g = -1;
                for (int o = 0; o < N; o++) begin
                    idx = (mptr + o) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("rnd_grant", 32'(req_ready), 32'(exp_rdy));
                if (g >= 0) begin
                    q.push_back('{g, int'(req_a[g*8 +: 8]) * int'(req_b[g*8 +: 8]), cyc});
                    mptr = (g + 1) % N;
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        do_reset(1);
        test_table();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
